// File: rtl/conv_encoder_tx.sv
// conv_encoder_tx
//   Rate-1/2, constraint length 3 convolutional encoder (generators 7 and 5
//   octal) for the transmit side of the link. Bytes arrive over a valid/ready
//   handshake into a one-byte holding register. They are serialised MSB first,
//   one bit per symbol strobe, and TAIL_LEN zero bits are appended after the
//   last byte of a frame so the trellis returns to state 00.
//
//   Optional feature macro: SCRAMBLE_EN
//     defined   : additive x^7+x^4+1 scrambler in front of the encoder, seeded
//                 with SCR_SEED at every frame start. Tail bits are not scrambled.
//     undefined : data bits go straight to the encoder and SCR_SEED is unused.
//
// Parameters
//   TAIL_LEN  zero tail bits per frame (K-1 = 2); legal range 0..7
//   SCR_SEED  scrambler seed, 7 bits
//
// Ports
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   sym_tick  one-cycle symbol-rate strobe; at most one symbol per tick
//   in_data   payload byte, sent MSB first
//   in_valid  in_data/in_last valid
//   in_last   byte closes the frame
//   in_ready  holding register empty
//   out       code symbol {c1,c0}; holds its value between strobes
//   en        one-cycle strobe, out valid (cycle after the consuming tick)
//   busy      frame in progress
module conv_encoder_tx #(
  parameter int unsigned TAIL_LEN = 2,
  parameter logic [6:0]  SCR_SEED = 7'h7F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sym_tick,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] out,
  output logic       en,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  localparam logic [2:0] TAIL_INIT = 3'(TAIL_LEN);

  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_last_q, hold_last_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic       last_q, last_d;
  // Data bits still waiting in shift_q; 0 in DATA means the byte is spent
  // and the next tick reloads from hold (or idles on underrun).
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] tail_cnt_q, tail_cnt_d;
  logic       s1_q, s1_d;
  logic       s0_q, s0_d;
  logic [1:0] out_q, out_d;
  logic       en_q, en_d;

  logic       load;        // hold -> shift, MSB emitted on the same tick
  logic       shift_step;  // next bit of the current byte emitted
  logic       tail_step;   // one zero tail bit emitted
  logic       data_bit;
  logic       enc_bit;
  logic       b;

  // Decode which kind of symbol (if any) this tick produces
  always_comb begin
    load       = 1'b0;
    shift_step = 1'b0;
    tail_step  = 1'b0;
    if (sym_tick) begin
      unique case (state_q)
        IDLE: load = hold_full_q;
        DATA: begin
          shift_step = (bit_cnt_q != 3'd0);
          load       = (bit_cnt_q == 3'd0) && hold_full_q;
        end
        TAIL: tail_step = 1'b1;
        default: ;
      endcase
    end
    data_bit = load ? hold_q[7] : shift_q[7];
  end

`ifdef SCRAMBLE_EN
  logic [6:0] scr_q, scr_d, scr_cur;
  logic       scr_fb;

  // A load out of IDLE starts a frame, so the seed replaces the register
  // for that first bit; reloads after an underrun keep the running state.
  always_comb begin
    scr_cur = (state_q == IDLE) ? SCR_SEED : scr_q;
    scr_fb  = scr_cur[6] ^ scr_cur[3];
    scr_d   = (load || shift_step) ? {scr_cur[5:0], scr_fb} : scr_q;
  end

  assign enc_bit = data_bit ^ scr_fb;

  always_ff @(posedge clk) begin
    scr_q <= scr_d;
  end
`else
  assign enc_bit = data_bit;

  // The seed has no role without the scrambler.
  logic unused_scr_seed;
  assign unused_scr_seed = ^SCR_SEED;
`endif

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    last_d      = last_q;
    bit_cnt_d   = bit_cnt_q;
    tail_cnt_d  = tail_cnt_q;
    s1_d        = s1_q;
    s0_d        = s0_q;
    out_d       = out_q;
    en_d        = 1'b0;
    b           = 1'b0;

    // Accept and unload are exclusive: accept needs hold empty, unload full.
    if (in_valid && !hold_full_q) begin
      hold_d      = in_data;
      hold_last_d = in_last;
      hold_full_d = 1'b1;
    end

    if (load) begin
      shift_d     = {hold_q[6:0], 1'b0};
      last_d      = hold_last_q;
      bit_cnt_d   = 3'd7;
      hold_full_d = 1'b0;
      state_d     = DATA;
    end

    if (shift_step) begin
      shift_d   = {shift_q[6:0], 1'b0};
      bit_cnt_d = bit_cnt_q - 3'd1;
    end

    if (load || shift_step || tail_step) begin
      b     = tail_step ? 1'b0 : enc_bit;
      out_d = {b ^ s1_q ^ s0_q, b ^ s0_q};
      en_d  = 1'b1;
      s1_d  = b;
      s0_d  = s1_q;
    end

    // Bit 0 of the closing byte: start the tail, or finish straight away
    if (shift_step && (bit_cnt_q == 3'd1) && last_q) begin
      if (TAIL_INIT == 3'd0) begin
        state_d = IDLE;
        s1_d    = 1'b0;
        s0_d    = 1'b0;
      end else begin
        state_d    = TAIL;
        tail_cnt_d = TAIL_INIT;
      end
    end

    if (tail_step) begin
      tail_cnt_d = tail_cnt_q - 3'd1;
      if (tail_cnt_q == 3'd1) begin
        state_d = IDLE;
        s1_d    = 1'b0;
        s0_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      last_q      <= 1'b0;
      bit_cnt_q   <= 3'd0;
      tail_cnt_q  <= 3'd0;
      s1_q        <= 1'b0;
      s0_q        <= 1'b0;
      out_q       <= 2'b00;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      last_q      <= last_d;
      bit_cnt_q   <= bit_cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      s1_q        <= s1_d;
      s0_q        <= s0_d;
      out_q       <= out_d;
      en_q        <= en_d;
    end
  end

  // Payload registers are only read while their control flags mark them live
  always_ff @(posedge clk) begin
    hold_q      <= hold_d;
    hold_last_q <= hold_last_d;
    shift_q     <= shift_d;
  end

  assign in_ready = !hold_full_q;
  assign out      = out_q;
  assign en       = en_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_conv_encoder_tx.sv
// tb_conv_encoder_tx
//   Self-checking bench for conv_encoder_tx. Expected symbols come from a
//   reference model that expands frames into bit streams and applies the
//   7/5 generator polynomials as a convolution over the stream.
`timescale 1ns/1ps
module tb_conv_encoder_tx;
  localparam int         TAIL_LEN = 2;
  localparam logic [6:0] SEED     = 7'h7F;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sym_tick = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [1:0] out;
  logic       en;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int tick_period = 6;
  int unsigned cyc = 0;

  logic [1:0]  got[$];
  int unsigned stamp[$];
  logic [1:0]  exp_q[$];
  logic [7:0]  fb_q[$];
  logic        ubits[$];
  int          out_glitch = 0;
  int          en_double = 0;
  logic [1:0]  prev_out = 2'b00;
  logic        prev_en = 1'b0;

  conv_encoder_tx #(.TAIL_LEN(TAIL_LEN), .SCR_SEED(SEED)) dut (
    .clk      (clk),
    .reset    (reset),
    .sym_tick (sym_tick),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out      (out),
    .en       (en),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en) begin
      got.push_back(out);
      stamp.push_back(cyc);
    end
    if (!en && !reset && out !== prev_out) out_glitch <= out_glitch + 1;
    if (en && prev_en) en_double <= en_double + 1;
    prev_out <= out;
    prev_en  <= en;
  end

  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (cnt >= tick_period - 1) begin
        sym_tick = 1'b1;
        cnt = 0;
      end else begin
        sym_tick = 1'b0;
        cnt++;
      end
    end
  end

  // Reference model: frame bytes -> (scrambled) bit stream
  function automatic void model_scramble();
    logic d;
`ifdef SCRAMBLE_EN
    logic x[$];
    logic f;
    for (int i = 6; i >= 0; i--) x.push_back(SEED[i]);
`endif
    ubits.delete();
    foreach (fb_q[j]) begin
      for (int k = 7; k >= 0; k--) begin
        d = fb_q[j][k];
`ifdef SCRAMBLE_EN
        f = x[x.size() - 7] ^ x[x.size() - 4];
        x.push_back(f);
        d = d ^ f;
`endif
        ubits.push_back(d);
      end
    end
  endfunction

  // Reference model: append tail, convolve with 111 and 101, append symbols
  function automatic void model_encode();
    logic u1, u2;
    for (int t = 0; t < TAIL_LEN; t++) ubits.push_back(1'b0);
    for (int n = 0; n < ubits.size(); n++) begin
      u1 = (n >= 1) ? ubits[n - 1] : 1'b0;
      u2 = (n >= 2) ? ubits[n - 2] : 1'b0;
      exp_q.push_back({ubits[n] ^ u1 ^ u2, ubits[n] ^ u2});
    end
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got.delete();
    stamp.delete();
    exp_q.delete();
    fb_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int guard = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    while (in_ready !== 1'b1 && guard < 3000) begin
      step();
      guard++;
    end
    if (guard >= 3000) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: in_ready=%b, required 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_syms(input int n);
    int guard = 0;
    while (got.size() < n && guard < 3000) begin
      step();
      guard++;
    end
    checks++;
    if (got.size() < n) begin
      errors++;
      $display("FAIL wait_syms: got %0d symbols, required %0d", got.size(), n);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy !== 1'b0 && guard < 3000) begin
      step();
      guard++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b required 0", en); end
    checks++; if (out !== 2'b00) begin errors++; $display("FAIL reset_out: got %b required 00", out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [1:0] g;
    clear_mon();
    fb_q = {8'hB0};
`ifdef SCRAMBLE_EN
    model_scramble();
    model_encode();
`else
    exp_q = {2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
`endif
    send_byte(8'hB0, 1'b1);
    wait_syms(10);
    repeat (30) step();
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_count: got %0d symbols required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < got.size()) ? got[i] : 2'bxx;
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL single_sym[%0d]: got %b required %b", i, g, exp_q[i]);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b required 0", busy); end
  endtask

  task automatic test_two_byte();
    logic [1:0] g;
    clear_mon();
    fb_q = {8'hFF, 8'h00};
    model_scramble();
    model_encode();
    send_byte(8'hFF, 1'b0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL two_ready_first: got %b required 0", in_ready); end
    send_byte(8'h00, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL two_ready_second: got %b required 0", in_ready); end
    wait_syms(18);
    repeat (20) step();
    checks++;
    if (got.size() != 18) begin errors++; $display("FAIL two_count: got %0d required 18", got.size()); end
    foreach (exp_q[i]) begin
      g = (i < got.size()) ? got[i] : 2'bxx;
      checks++;
      if (g !== exp_q[i]) begin errors++; $display("FAIL two_sym[%0d]: got %b required %b", i, g, exp_q[i]); end
    end
    for (int i = 1; i < stamp.size(); i++) begin
      checks++;
      if (int'(stamp[i] - stamp[i - 1]) != tick_period) begin
        errors++;
        $display("FAIL two_spacing[%0d]: got %0d clks required %0d", i, stamp[i] - stamp[i - 1], tick_period);
      end
    end
    wait_idle();
  endtask

  task automatic test_underrun();
    logic [1:0] g;
    logic [7:0] a, c;
    a = 8'($urandom);
    c = 8'($urandom);
    clear_mon();
    fb_q = {a, c};
    model_scramble();
    model_encode();
    send_byte(a, 1'b0);
    wait_syms(8);
    repeat (20 * tick_period) step();
    checks++; if (got.size() != 8) begin errors++; $display("FAIL underrun_gap: got %0d symbols required 8", got.size()); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL underrun_busy: got %b required 1", busy); end
    send_byte(c, 1'b1);
    wait_syms(18);
    repeat (20) step();
    checks++;
    if (got.size() != 18) begin errors++; $display("FAIL underrun_count: got %0d required 18", got.size()); end
    foreach (exp_q[i]) begin
      g = (i < got.size()) ? got[i] : 2'bxx;
      checks++;
      if (g !== exp_q[i]) begin errors++; $display("FAIL underrun_sym[%0d]: got %b required %b", i, g, exp_q[i]); end
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    logic [1:0] g;
    clear_mon();
    send_byte(8'($urandom), 1'b0);
    send_byte(8'($urandom), 1'b0);
    wait_syms(3);
    while (sym_tick !== 1'b1 && guard < 50) begin
      step();
      guard++;
    end
    reset = 1'b1;
    step();
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL midreset_en: got %b required 0", en); end
    checks++; if (out !== 2'b00) begin errors++; $display("FAIL midreset_out: got %b required 00", out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b required 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy); end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL midreset_syms: got %0d required 3", got.size()); end
    reset = 1'b0;
    repeat (40) step();
    checks++; if (got.size() != 3) begin errors++; $display("FAIL midreset_no_tail: got %0d symbols required 3", got.size()); end
    clear_mon();
    fb_q = {8'hB0};
`ifdef SCRAMBLE_EN
    model_scramble();
    model_encode();
`else
    exp_q = {2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
`endif
    send_byte(8'hB0, 1'b1);
    wait_syms(10);
    repeat (20) step();
    checks++; if (got.size() != 10) begin errors++; $display("FAIL midreset_next_count: got %0d required 10", got.size()); end
    foreach (exp_q[i]) begin
      g = (i < got.size()) ? got[i] : 2'bxx;
      checks++;
      if (g !== exp_q[i]) begin errors++; $display("FAIL midreset_next_sym[%0d]: got %b required %b", i, g, exp_q[i]); end
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [1:0] g;
    clear_mon();
    fb_q = {8'hB0};
    model_scramble();
    model_encode();
    model_scramble();
    model_encode();
    send_byte(8'hB0, 1'b1);
    send_byte(8'hB0, 1'b1);
    wait_syms(20);
    repeat (20) step();
    checks++; if (got.size() != 20) begin errors++; $display("FAIL b2b_count: got %0d required 20", got.size()); end
    foreach (exp_q[i]) begin
      g = (i < got.size()) ? got[i] : 2'bxx;
      checks++;
      if (g !== exp_q[i]) begin errors++; $display("FAIL b2b_sym[%0d]: got %b required %b", i, g, exp_q[i]); end
    end
    for (int i = 1; i < stamp.size(); i++) begin
      checks++;
      if (int'(stamp[i] - stamp[i - 1]) != tick_period) begin
        errors++;
        $display("FAIL b2b_spacing[%0d]: got %0d clks required %0d", i, stamp[i] - stamp[i - 1], tick_period);
      end
    end
    wait_idle();
  endtask

`ifdef SCRAMBLE_EN
  task automatic test_scramble();
    logic [1:0] g;
    clear_mon();
    ubits = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    model_encode();
    send_byte(8'h00, 1'b1);
    wait_syms(10);
    repeat (20) step();
    checks++; if (got.size() != 10) begin errors++; $display("FAIL scr_count: got %0d required 10", got.size()); end
    foreach (exp_q[i]) begin
      g = (i < got.size()) ? got[i] : 2'bxx;
      checks++;
      if (g !== exp_q[i]) begin errors++; $display("FAIL scr_sym[%0d]: got %b required %b", i, g, exp_q[i]); end
    end
    wait_idle();
  endtask
`endif

  task automatic test_random();
    logic [1:0] g;
    int n;
    for (int f = 0; f < 6; f++) begin
      clear_mon();
      tick_period = $urandom_range(2, 8);
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) fb_q.push_back(8'($urandom));
      model_scramble();
      model_encode();
      for (int j = 0; j < n; j++) begin
        repeat ($urandom_range(0, 100)) step();
        send_byte(fb_q[j], (j == n - 1));
      end
      wait_syms(8 * n + TAIL_LEN);
      repeat (20) step();
      checks++;
      if (got.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d required %0d", f, got.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        g = (i < got.size()) ? got[i] : 2'bxx;
        checks++;
        if (g !== exp_q[i]) begin errors++; $display("FAIL rand%0d_sym[%0d]: got %b required %b", f, i, g, exp_q[i]); end
      end
      wait_idle();
    end
    tick_period = 6;
    repeat (10) step();
  endtask

  task automatic test_strobes();
    checks++; if (out_glitch != 0) begin errors++; $display("FAIL out_hold: out changed %0d times without en, required 0", out_glitch); end
    checks++; if (en_double != 0) begin errors++; $display("FAIL en_width: en high on %0d consecutive cycles, required 0", en_double); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_byte();
    test_underrun();
    test_reset_mid();
    test_back_to_back();
`ifdef SCRAMBLE_EN
    test_scramble();
`endif
    test_random();
    test_strobes();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
